// File: rtl/gf180mcu_fd_sc_mcu7t5v0__dist3_pkg.sv
// Shared types for the 1-to-3 round-robin distributor and its pick logic.
// Channels are numbered 1..3 so the index matches the Z1/Z2/Z3 port names.
package gf180mcu_fd_sc_mcu7t5v0__dist3_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  typedef logic [1:0] chan_t;

  localparam chan_t RESET_LAST = 2'd3;

  function automatic chan_t next_chan(input chan_t c);
    return (c == 2'd3) ? 2'd1 : c + 2'd1;
  endfunction

  function automatic logic chan_en(input logic [2:0] en, input chan_t c);
    logic b;
    case (c)
      2'd1:    b = en[0];
      2'd2:    b = en[1];
      2'd3:    b = en[2];
      default: b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__rr_pick3.sv
// Combinational 3-way round-robin pick: first enabled channel strictly after last.
// Zero latency; falls back to last when only last is enabled, flags none when en is 0.
module gf180mcu_fd_sc_mcu7t5v0__rr_pick3
  import gf180mcu_fd_sc_mcu7t5v0__dist3_pkg::*;
(
  input  chan_t       last,
  input  logic [2:0]  en,
  output chan_t       pick,
  output logic        none
);

  chan_t c1;
  chan_t c2;

  assign c1 = next_chan(last);
  assign c2 = next_chan(c1);

  always_comb begin
    none = (en == 3'b000);
    pick = last;
    if (chan_en(en, c1)) begin
      pick = c1;
    end else if (chan_en(en, c2)) begin
      pick = c2;
    end
  end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__dist3_rr.sv
// Registered 1-to-3 round-robin distributor with a one-word buffer; 1-cycle latency.
// A held word stays on its channel until consumed; IN_READY drops while it stalls.
module gf180mcu_fd_sc_mcu7t5v0__dist3_rr
  import gf180mcu_fd_sc_mcu7t5v0__dist3_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RN,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [W-1:0] IN_DATA,
  input  logic [2:0]   EN,
  output logic         Z1_VALID,
  output logic         Z2_VALID,
  output logic         Z3_VALID,
  input  logic         Z1_READY,
  input  logic         Z2_READY,
  input  logic         Z3_READY,
  output logic [W-1:0] Z_DATA,
  output logic         BUSY
);

  state_e       state_q, state_d;
  chan_t        sel_q, sel_d;
  chan_t        last_q, last_d;
  logic [W-1:0] data_q, data_d;

  chan_t pick;
  logic  none_en;
  logic  sel_rdy;
  logic  fire;
  logic  load;

  gf180mcu_fd_sc_mcu7t5v0__rr_pick3 u_pick (
    .last (last_q),
    .en   (EN),
    .pick (pick),
    .none (none_en)
  );

  // Only the selected channel's READY matters; the others are ignored.
  assign sel_rdy  = chan_en({Z3_READY, Z2_READY, Z1_READY}, sel_q);
  assign fire     = (state_q == FULL) && sel_rdy;
  assign IN_READY = !none_en && ((state_q == EMPTY) || fire);
  assign load     = IN_VALID && IN_READY;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    data_d  = data_q;
    if (load) begin
      state_d = FULL;
      sel_d   = pick;
      last_d  = pick;
      data_d  = IN_DATA;
    end else if (fire) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= EMPTY;
      sel_q   <= RESET_LAST;
      last_q  <= RESET_LAST;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      data_q  <= data_d;
    end
  end

  // Valids come straight from flops, so READY never reaches them combinationally.
  assign Z1_VALID = (state_q == FULL) && (sel_q == 2'd1);
  assign Z2_VALID = (state_q == FULL) && (sel_q == 2'd2);
  assign Z3_VALID = (state_q == FULL) && (sel_q == 2'd3);
  assign Z_DATA   = data_q;
  assign BUSY     = (state_q == FULL);

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__dist3_rr.sv
// Randomised scoreboard bench for the round-robin distributor (W=8 and W=1 builds).
module tb_gf180mcu_fd_sc_mcu7t5v0__dist3_rr;

  logic       clk;
  logic       rn;
  logic       in_valid;
  logic [7:0] in_data;
  logic [2:0] en;
  logic [2:0] rdy;

  logic       a_in_ready, a_z1, a_z2, a_z3, a_busy;
  logic [7:0] a_data;
  logic       b_in_ready, b_z1, b_z2, b_z3, b_busy;
  logic [0:0] b_data;

  gf180mcu_fd_sc_mcu7t5v0__dist3_rr #(.W(8)) dut_a (
    .CLK(clk), .RN(rn), .IN_VALID(in_valid), .IN_READY(a_in_ready), .IN_DATA(in_data),
    .EN(en), .Z1_VALID(a_z1), .Z2_VALID(a_z2), .Z3_VALID(a_z3),
    .Z1_READY(rdy[0]), .Z2_READY(rdy[1]), .Z3_READY(rdy[2]),
    .Z_DATA(a_data), .BUSY(a_busy)
  );

  gf180mcu_fd_sc_mcu7t5v0__dist3_rr #(.W(1)) dut_b (
    .CLK(clk), .RN(rn), .IN_VALID(in_valid), .IN_READY(b_in_ready), .IN_DATA(in_data[0]),
    .EN(en), .Z1_VALID(b_z1), .Z2_VALID(b_z2), .Z3_VALID(b_z3),
    .Z1_READY(rdy[0]), .Z2_READY(rdy[1]), .Z3_READY(rdy[2]),
    .Z_DATA(b_data), .BUSY(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    int         ch;
  } exp_t;

  exp_t q[$];
  int   m_last = 3;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   z2_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference pick: walk the cyclic order 1->2->3->1 starting just after last.
  function automatic int ref_pick(input int last, input logic [2:0] e);
    for (int k = 1; k <= 3; k++) begin
      int c;
      c = (last + k - 1) % 3 + 1;
      if (e[c-1]) return c;
    end
    return last;
  endfunction

  function automatic logic [2:0] onehot(input int ch);
    logic [2:0] v;
    v = 3'b000;
    v[ch-1] = 1'b1;
    return v;
  endfunction

  // Monitor: output side first (compare/pop), then readiness, then capture new loads.
  always @(negedge clk) begin
    logic       fire_m;
    logic       rdy_m;
    logic [7:0] dtmp;
    exp_t       e;
    if (rn) begin
      if (a_z2) z2_seen++;
      fire_m = 1'b0;
      if (q.size() > 0) begin
        e = q[0];
        dtmp = e.d;
        chk("a_valid", {29'd0, a_z3, a_z2, a_z1}, {29'd0, onehot(e.ch)});
        chk("a_data", {24'd0, a_data}, {24'd0, e.d});
        chk("a_busy", {31'd0, a_busy}, 32'd1);
        chk("b_valid", {29'd0, b_z3, b_z2, b_z1}, {29'd0, onehot(e.ch)});
        chk("b_data", {31'd0, b_data}, {31'd0, dtmp[0]});
        fire_m = rdy[e.ch-1];
        if (fire_m) void'(q.pop_front());
      end else begin
        chk("a_idle_valid", {29'd0, a_z3, a_z2, a_z1}, 32'd0);
        chk("a_idle_busy", {31'd0, a_busy}, 32'd0);
        chk("b_idle_valid", {29'd0, b_z3, b_z2, b_z1}, 32'd0);
      end
      rdy_m = (en != 3'b000) && ((q.size() == 0) || fire_m);
      chk("a_in_ready", {31'd0, a_in_ready}, {31'd0, rdy_m});
      chk("b_in_ready", {31'd0, b_in_ready}, {31'd0, rdy_m});
      if (in_valid && rdy_m) begin
        e.d  = in_data;
        e.ch = ref_pick(m_last, en);
        m_last = e.ch;
        q.push_back(e);
      end
    end
  end

  task automatic do_reset();
    rn = 1'b0;
    q.delete();
    m_last = 3;
    #1;
    chk("rst_valid", {29'd0, a_z3, a_z2, a_z1}, 32'd0);
    chk("rst_busy", {31'd0, a_busy}, 32'd0);
    chk("rst_data", {24'd0, a_data}, 32'd0);
    chk("rst_b_data", {31'd0, b_data}, 32'd0);
    @(negedge clk);
    #2 rn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Offer one word and hold it until accepted, bounded by a cycle budget.
  task automatic send(input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (a_in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    int t0;
    int z2_0;
    logic [7:0] r;
    rn = 1'b0; in_valid = 1'b0; in_data = 8'h00; en = 3'b000; rdy = 3'b000;
    #3;
    do_reset();

    // Back-to-back to all three channels: four words in four cycles.
    en = 3'b111; rdy = 3'b111;
    t0 = cyc;
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    chk("b2b_cycles", cyc - t0, 32'd4);
    repeat (3) @(posedge clk);
    #1;

    // Z2 disabled: order alternates Z1, Z3.
    do_reset();
    en = 3'b101;
    z2_0 = z2_seen;
    send(8'h51); send(8'h52); send(8'h53); send(8'h54);
    repeat (3) @(posedge clk);
    #1;
    chk("z2_never", z2_seen - z2_0, 32'd0);

    // Stall on Z2 while EN changes underneath; word must stay put.
    do_reset();
    en = 3'b111; rdy = 3'b101;
    send(8'h01); send(8'hA5);
    en = 3'b001; in_valid = 1'b1; in_data = 8'h5A;
    repeat (5) begin
      @(negedge clk);
      chk("stall_z2_valid", {31'd0, a_z2}, 32'd1);
      chk("stall_data", {24'd0, a_data}, 32'hA5);
      chk("stall_in_ready", {31'd0, a_in_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    rdy = 3'b111;
    send(8'h5A);
    @(negedge clk);
    chk("after_stall_z1", {31'd0, a_z1}, 32'd1);
    chk("after_stall_data", {24'd0, a_data}, 32'h5A);
    @(posedge clk);
    #1;

    // No channel enabled: nothing accepted until EN[1] turns on.
    do_reset();
    en = 3'b000; in_valid = 1'b1; in_data = 8'h77;
    repeat (6) begin
      @(negedge clk);
      chk("en0_in_ready", {31'd0, a_in_ready}, 32'd0);
      chk("en0_busy", {31'd0, a_busy}, 32'd0);
    end
    @(posedge clk);
    #1;
    en = 3'b010;
    send(8'h77);
    @(negedge clk);
    chk("en010_z2", {31'd0, a_z2}, 32'd1);
    @(posedge clk);
    #1;

    // Reset while a word sits on Z3; next word restarts at Z1.
    do_reset();
    en = 3'b111; rdy = 3'b011;
    send(8'h0A); send(8'h0B); send(8'h0C);
    @(negedge clk);
    chk("held_z3", {31'd0, a_z3}, 32'd1);
    #1;
    do_reset();
    rdy = 3'b111;
    send(8'h0D);
    @(negedge clk);
    chk("post_rst_z1", {31'd0, a_z1}, 32'd1);
    @(posedge clk);
    #1;

    // Random traffic; data bit 0 alternates for the single-bit build.
    for (int i = 0; i < 600; i++) begin
      r = 8'($urandom());
      en = ($urandom_range(0, 9) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
      rdy = 3'($urandom());
      in_valid = ($urandom_range(0, 3) != 0);
      in_data = {r[7:1], 1'(i % 2)};
      @(posedge clk);
      #1;
    end

    in_valid = 1'b0; en = 3'b111; rdy = 3'b111;
    repeat (5) @(posedge clk);
    #1;
    chk("drain_empty", q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
